// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline interlock and operand-forwarding controller for the
// five-stage integer pipeline. Tracks shadow destination state for EX and MEM,
// raises load-use / branch-operand stalls, registers the EX forwarding selects
// and sequences the fixed-latency multiply that holds EX.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_load,
  input  logic       id_mul,
  input  logic       id_branch,
  output logic       stall_id,
  output logic       bubble_ex,
  output logic       ex_hold,
  output logic       bubble_mem,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       mul_busy
);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
  } shadow_t;

  // Counter value loaded when a multiply enters EX; it leaves on the 1->0 edge.
  localparam logic [3:0] MUL_LOAD  = 4'(MUL_LAT - 1);
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // A producer feeds a source only if it really writes a non-zero register.
  function automatic logic producer_match(input shadow_t    p,
                                          input logic [4:0] src,
                                          input logic       used);
    return used && p.valid && p.regwrite && (p.rd != 5'd0) && (p.rd == src);
  endfunction

  // The younger producer (the one now in EX) wins over the older one in MEM.
  function automatic logic [1:0] fwd_select(input logic ex_hit,
                                            input logic mem_hit);
    logic [1:0] sel;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  state_e     state_q,    state_d;
  logic [3:0] cnt_q,      cnt_d;
  shadow_t    ex_q,       ex_d;
  shadow_t    mem_q,      mem_d;
  logic [1:0] fwd_a_q,    fwd_a_d;
  logic [1:0] fwd_b_q,    fwd_b_d;
  logic       mul_busy_q, mul_busy_d;

  logic ex_rs1_hit, ex_rs2_hit, mem_rs1_hit, mem_rs2_hit;
  logic ex_hit_any, mem_hit_any;
  logic load_use, branch_haz, hazard;
  logic run_adv, mul_end, advance, mul_start;

  assign ex_rs1_hit  = producer_match(ex_q,  id_rs1, id_use_rs1);
  assign ex_rs2_hit  = producer_match(ex_q,  id_rs2, id_use_rs2);
  assign mem_rs1_hit = producer_match(mem_q, id_rs1, id_use_rs1);
  assign mem_rs2_hit = producer_match(mem_q, id_rs2, id_use_rs2);
  assign ex_hit_any  = ex_rs1_hit | ex_rs2_hit;
  assign mem_hit_any = mem_rs1_hit | mem_rs2_hit;

  // Load in EX cannot forward yet; branches compare in ID and only see busW,
  // so any EX producer or a load still in MEM forces a wait.
  assign load_use   = ex_hit_any & ex_q.load;
  assign branch_haz = id_branch & (ex_hit_any | (mem_hit_any & mem_q.load));
  assign hazard     = id_valid & (load_use | branch_haz);

  // The ID instruction moves into EX on a clean RUN cycle, or on the edge that
  // retires a multiply from EX.
  assign run_adv   = (state_q == ST_RUN) & ~hazard;
  assign mul_end   = (state_q == ST_MUL) & (cnt_q <= 4'd1);
  assign advance   = run_adv | mul_end;
  assign mul_start = advance & id_valid & id_mul;

  assign fwd_a    = fwd_a_q;
  assign fwd_b    = fwd_b_q;
  assign mul_busy = mul_busy_q;

  // State register plus shadow stages and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      ex_q       <= '0;
      mem_q      <= '0;
      fwd_a_q    <= FWD_RF;
      fwd_b_q    <= FWD_RF;
      mul_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
      mul_busy_q <= mul_busy_d;
    end
  end

  // Next-state logic for RUN/MUL and the multiply latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mul_start) begin
          state_d = ST_MUL;
          cnt_d   = MUL_LOAD;
        end else begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      end
      ST_MUL: begin
        if (mul_end) begin
          if (mul_start) begin
            state_d = ST_MUL;
            cnt_d   = MUL_LOAD;
          end else begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = ST_MUL;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Shadow-stage movement and forwarding selects for the instruction entering EX.
  always_comb begin
    ex_d       = ex_q;
    mem_d      = mem_q;
    fwd_a_d    = fwd_a_q;
    fwd_b_d    = fwd_b_q;
    mul_busy_d = (state_q == ST_MUL) | mul_start;
    if (advance) begin
      mem_d = ex_q;
      if (id_valid) begin
        ex_d.valid    = 1'b1;
        ex_d.rd       = id_rd;
        ex_d.regwrite = id_regwrite;
        ex_d.load     = id_load;
        fwd_a_d       = fwd_select(ex_rs1_hit & ~ex_q.load, mem_rs1_hit);
        fwd_b_d       = fwd_select(ex_rs2_hit & ~ex_q.load, mem_rs2_hit);
      end else begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
      end
    end else if (state_q == ST_RUN) begin
      // Stall cycle: a bubble enters EX while the older entry drains on.
      ex_d    = '0;
      mem_d   = ex_q;
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
    end else begin
      // Multiply still occupying EX: EX holds, MEM receives a bubble.
      ex_d  = ex_q;
      mem_d = '0;
    end
  end

  // Combinational pipeline control outputs; MUL overrides data hazards.
  always_comb begin
    stall_id   = 1'b0;
    bubble_ex  = 1'b0;
    ex_hold    = 1'b0;
    bubble_mem = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall_id  = hazard;
        bubble_ex = hazard;
      end
      ST_MUL: begin
        stall_id   = 1'b1;
        ex_hold    = 1'b1;
        bubble_mem = 1'b1;
      end
      default: begin
        stall_id   = 1'b0;
        bubble_ex  = 1'b0;
        ex_hold    = 1'b0;
        bubble_mem = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Observed vector per cycle:
// {stall_id, bubble_ex, ex_hold, bubble_mem, fwd_a, fwd_b, mul_busy}.
module tb_hazard_ctrl;

  logic       clock;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_load;
  logic       id_mul;
  logic       id_branch;
  logic       stall_id;
  logic       bubble_ex;
  logic       ex_hold;
  logic       bubble_mem;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       mul_busy;
  logic [8:0] obs;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_load    (id_load),
    .id_mul     (id_mul),
    .id_branch  (id_branch),
    .stall_id   (stall_id),
    .bubble_ex  (bubble_ex),
    .ex_hold    (ex_hold),
    .bubble_mem (bubble_mem),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .mul_busy   (mul_busy)
  );

  assign obs = {stall_id, bubble_ex, ex_hold, bubble_mem, fwd_a, fwd_b, mul_busy};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected per-cycle vectors for the multiply scenarios.
  logic [8:0] exp_mul [0:6] = '{9'b0000_00_00_0, 9'b1011_00_00_1, 9'b1011_00_00_1,
                                9'b1011_00_00_1, 9'b0000_01_00_1, 9'b0000_00_00_0,
                                9'b0000_00_00_0};
  logic [8:0] exp_b2b [0:8] = '{9'b0000_00_00_0, 9'b1011_00_00_1, 9'b1011_00_00_1,
                                9'b1011_00_00_1, 9'b1011_01_00_1, 9'b1011_01_00_1,
                                9'b1011_01_00_1, 9'b0000_00_00_1, 9'b0000_00_00_0};

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic ml, input logic br);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_load = ld; id_mul = ml; id_branch = br;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic flush();
    idle();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #12;
    total++;
    if (obs !== 9'b0000_00_00_0) begin
      bad++; $display("FAIL reset_state: got %b want %b", obs, 9'b0000_00_00_0);
    end
    reset = 1'b1;
  endtask

  task automatic test_alu_fwd();
    logic [8:0] e [0:8] = '{9'b0, 9'b0, 9'b0000_01_00_0, 9'b0, 9'b0,
                            9'b0000_10_01_0, 9'b0, 9'b0, 9'b0000_01_00_0};
    flush();
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: drive(1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0);
        1: drive(1'b1, 5'd3,  1'b1, 5'd4,  1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0);
        2: drive(1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        3: drive(1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        4: drive(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        5: drive(1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        6: drive(1'b1, 5'd1,  1'b1, 5'd2,  1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        7: drive(1'b1, 5'd10, 1'b1, 5'd5,  1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        default: idle();
      endcase
      #1;
      total++;
      if (obs !== e[c]) begin
        bad++; $display("FAIL alu_fwd c%0d: got %b want %b", c, obs, e[c]);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    logic [8:0] e [0:5] = '{9'b0, 9'b1100_00_00_0, 9'b0, 9'b0000_00_10_0, 9'b0, 9'b0};
    flush();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        1: drive(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        2: drive(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        4: drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        5: drive(1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        default: idle();
      endcase
      #1;
      total++;
      if (obs !== e[c]) begin
        bad++; $display("FAIL load_use c%0d: got %b want %b", c, obs, e[c]);
      end
      tick();
    end
  endtask

  task automatic test_reg0();
    flush();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    total++;
    if (obs !== 9'b0) begin
      bad++; $display("FAIL reg0_stall: got %b want %b", obs, 9'b0);
    end
    tick();
    idle();
    #1;
    total++;
    if (obs !== 9'b0) begin
      bad++; $display("FAIL reg0_fwd: got %b want %b", obs, 9'b0);
    end
  endtask

  task automatic test_branch();
    logic [8:0] e [0:7] = '{9'b0, 9'b1100_00_00_0, 9'b1100_00_00_0, 9'b0, 9'b0,
                            9'b1100_00_00_0, 9'b0, 9'b0000_10_00_0};
    flush();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: drive(1'b1, 5'd1,  1'b1, 5'd0, 1'b0, 5'd7,  1'b1, 1'b1, 1'b0, 1'b0);
        1, 2, 3:
           drive(1'b1, 5'd7,  1'b1, 5'd8, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        4: drive(1'b1, 5'd1,  1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        5, 6:
           drive(1'b1, 5'd12, 1'b1, 5'd3, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1);
        default: idle();
      endcase
      #1;
      total++;
      if (obs !== e[c]) begin
        bad++; $display("FAIL branch c%0d: got %b want %b", c, obs, e[c]);
      end
      tick();
    end
  endtask

  task automatic test_mul();
    int n_busy = 0;
    int n_stall = 0;
    int n_bm = 0;
    flush();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0);
        1, 2, 3:
           drive(1'b1, 5'd9, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        default: idle();
      endcase
      #1;
      n_busy  += int'(mul_busy);
      n_stall += int'(stall_id);
      n_bm    += int'(bubble_mem);
      total++;
      if (obs !== exp_mul[c]) begin
        bad++; $display("FAIL mul c%0d: got %b want %b", c, obs, exp_mul[c]);
      end
      tick();
    end
    total++;
    if (n_busy != 4) begin
      bad++; $display("FAIL mul_busy_cycles: got %0d want 4", n_busy);
    end
    total++;
    if (n_stall != 3) begin
      bad++; $display("FAIL mul_stall_cycles: got %0d want 3", n_stall);
    end
    total++;
    if (n_bm != 3) begin
      bad++; $display("FAIL mul_bubble_mem_cycles: got %0d want 3", n_bm);
    end
  endtask

  task automatic test_back_to_back();
    flush();
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0);
        1, 2, 3:
           drive(1'b1, 5'd9, 1'b1, 5'd2, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
        default: idle();
      endcase
      #1;
      total++;
      if (obs !== exp_b2b[c]) begin
        bad++; $display("FAIL back_to_back c%0d: got %b want %b", c, obs, exp_b2b[c]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_mul();
    flush();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 1'b1, 5'd2, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    total++;
    if (obs !== 9'b1011_01_00_1) begin
      bad++; $display("FAIL pre_reset_mul: got %b want %b", obs, 9'b1011_01_00_1);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (obs !== 9'b0) begin
      bad++; $display("FAIL async_reset_mul: got %b want %b", obs, 9'b0);
    end
    #2 reset = 1'b1;
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    total++;
    if (obs !== 9'b0) begin
      bad++; $display("FAIL post_reset_flow: got %b want %b", obs, 9'b0);
    end
    tick();
    idle();
    #1;
    total++;
    if (obs !== 9'b0) begin
      bad++; $display("FAIL post_reset_fwd: got %b want %b", obs, 9'b0);
    end
  endtask

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_reg0();
    test_branch();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
